// File: rtl/serial_byte_arbiter.sv
// Time-shares one deserializer among NUM_SRC serial sources, one byte per grant,
// round-robin, and hands each finished byte plus its source ID to the downstream queue.
module serial_byte_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SW      = $clog2(NUM_SRC)
) (
  input  logic               clock_100KHZ,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [NUM_SRC-1:0] src_data_in,
  input  logic [NUM_SRC-1:0] src_write_in,
  output logic [NUM_SRC-1:0] src_grant,
  output logic               deser_data_in,
  output logic               deser_write_in,
  input  logic               deser_status,
  input  logic               deser_data_ready,
  input  logic [7:0]         deser_data,
  output logic               deser_ack,
  input  logic               q_full,
  output logic               q_push,
  output logic [7:0]         q_data,
  output logic [SW-1:0]      q_src,
  output logic [15:0]        bytes_total
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    STREAM,
    DRAIN,
    PUSH,
    RELEASE
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [SW-1:0] rr;
  logic [SW-1:0] g;
  logic [SW-1:0] pick;
  logic          pick_valid;
  logic [3:0]    bc;
  logic          in_stream;
  logic          fwd_write;
  logic          push_en;

  // Scan downward from the farthest offset so the nearest requester at or after rr wins.
  always_comb begin
    logic [SW-1:0] idx;
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SW'((int'(rr) + k) % NUM_SRC);
      if (src_req[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  assign in_stream      = (state == STREAM);
  assign fwd_write      = in_stream & src_write_in[g] & deser_status;
  assign deser_write_in = fwd_write;
  assign deser_data_in  = in_stream & src_data_in[g];

  always_ff @(posedge clock_100KHZ or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    push_en    = 1'b0;
    case (state)
      IDLE:    if (pick_valid) next_state = GRANT;
      GRANT:   if (deser_status) next_state = STREAM;
      STREAM:  if (fwd_write && bc == 4'd7) next_state = DRAIN;
      DRAIN:   if (deser_data_ready) next_state = PUSH;
      PUSH: begin
        if (!q_full) begin
          push_en    = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: if (!deser_data_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The eighth forwarded bit also drops the grant, so the source sees it fall entering DRAIN.
  always_ff @(posedge clock_100KHZ or negedge reset) begin
    if (!reset) begin
      rr          <= '0;
      g           <= '0;
      bc          <= '0;
      src_grant   <= '0;
      q_push      <= 1'b0;
      deser_ack   <= 1'b0;
      q_data      <= '0;
      q_src       <= '0;
      bytes_total <= '0;
    end else begin
      q_push    <= push_en;
      deser_ack <= push_en;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            g         <= pick;
            src_grant <= NUM_SRC'(1) << pick;
          end
        end
        GRANT: begin
          if (deser_status) bc <= '0;
        end
        STREAM: begin
          if (fwd_write) begin
            bc <= bc + 4'd1;
            if (bc == 4'd7) src_grant <= '0;
          end
        end
        PUSH: begin
          if (push_en) begin
            q_data      <= deser_data;
            q_src       <= g;
            bytes_total <= bytes_total + 16'd1;
          end
        end
        RELEASE: begin
          if (!deser_data_ready) rr <= (g == SW'(NUM_SRC - 1)) ? '0 : g + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_arbiter.sv
// Bench for serial_byte_arbiter: behavioural deserializer, scripted sources and a
// scoreboard of expected queue pushes checked whenever the DUT strobes q_push.
module tb_serial_byte_arbiter;

  localparam int NUM_SRC = 4;
  localparam int SW      = 2;

  logic               clock_100KHZ = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_SRC-1:0] src_req = '0;
  logic [NUM_SRC-1:0] src_data_in = '0;
  logic [NUM_SRC-1:0] src_write_in = '0;
  logic [NUM_SRC-1:0] src_grant;
  logic               deser_data_in;
  logic               deser_write_in;
  logic               deser_status;
  logic               deser_data_ready;
  logic [7:0]         deser_data;
  logic               deser_ack;
  logic               q_full = 1'b0;
  logic               q_push;
  logic [7:0]         q_data;
  logic [SW-1:0]      q_src;
  logic [15:0]        bytes_total;

  serial_byte_arbiter #(.NUM_SRC(NUM_SRC)) dut (
    .clock_100KHZ     (clock_100KHZ),
    .reset            (reset),
    .src_req          (src_req),
    .src_data_in      (src_data_in),
    .src_write_in     (src_write_in),
    .src_grant        (src_grant),
    .deser_data_in    (deser_data_in),
    .deser_write_in   (deser_write_in),
    .deser_status     (deser_status),
    .deser_data_ready (deser_data_ready),
    .deser_data       (deser_data),
    .deser_ack        (deser_ack),
    .q_full           (q_full),
    .q_push           (q_push),
    .q_data           (q_data),
    .q_src            (q_src),
    .bytes_total      (bytes_total)
  );

  always #5 clock_100KHZ = ~clock_100KHZ;

  typedef struct {
    logic [7:0]    data;
    logic [SW-1:0] src;
    logic [15:0]   total;
  } exp_t;

  exp_t        expQ[$];
  int          checkCount = 0;
  int          passCount = 0;
  int          pushSeen = 0;
  int          expectedPushes = 0;
  int          rrModel = 0;
  logic [15:0] expTotal = '0;
  logic [2:0]  mCount;
  logic [7:0]  mShift;

  // Deserializer stand-in: shifts MSB-first, holds the byte until acked, shares the reset net.
  always @(posedge clock_100KHZ or negedge reset) begin
    if (!reset) begin
      mCount           <= '0;
      mShift           <= '0;
      deser_data_ready <= 1'b0;
      deser_data       <= '0;
    end else if (deser_ack) begin
      deser_data_ready <= 1'b0;
    end else if (deser_write_in && !deser_data_ready) begin
      mShift <= {mShift[6:0], deser_data_in};
      if (mCount == 3'd7) begin
        deser_data_ready <= 1'b1;
        deser_data       <= {mShift[6:0], deser_data_in};
      end
      mCount <= mCount + 3'd1;
    end
  end

  assign deser_status = ~deser_data_ready;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  always @(negedge clock_100KHZ) begin
    if (reset && q_push) begin
      exp_t e;
      pushSeen++;
      checkOutput("ack_with_push", {31'd0, deser_ack}, 32'd1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_push", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("q_data", {24'd0, q_data}, {24'd0, e.data});
        checkOutput("q_src", {30'd0, q_src}, {30'd0, e.src});
        checkOutput("bytes_total", {16'd0, bytes_total}, {16'd0, e.total});
      end
    end
  end

  function automatic int pickNext(input logic [NUM_SRC-1:0] req, input int rrIn);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (req[(rrIn + k) % NUM_SRC]) return (rrIn + k) % NUM_SRC;
    end
    return 0;
  endfunction

  task automatic checkResetState();
    checkOutput("rst_grant", {28'd0, src_grant}, 32'd0);
    checkOutput("rst_q_push", {31'd0, q_push}, 32'd0);
    checkOutput("rst_deser_ack", {31'd0, deser_ack}, 32'd0);
    checkOutput("rst_q_data", {24'd0, q_data}, 32'd0);
    checkOutput("rst_q_src", {30'd0, q_src}, 32'd0);
    checkOutput("rst_bytes_total", {16'd0, bytes_total}, 32'd0);
    checkOutput("rst_deser_write", {31'd0, deser_write_in}, 32'd0);
    checkOutput("rst_deser_data", {31'd0, deser_data_in}, 32'd0);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    src_req = '0;
    src_write_in = '0;
    src_data_in = '0;
    q_full = 1'b0;
    repeat (2) @(negedge clock_100KHZ);
    expQ.delete();
    pushSeen = 0;
    expectedPushes = 0;
    expTotal = '0;
    rrModel = 0;
    reset = 1'b1;
    @(negedge clock_100KHZ);
  endtask

  // Streams one byte from the source the round-robin model expects to win; with a noise
  // source, every bit is followed by a gap cycle in which only the noise source writes.
  task automatic applyStimulus(input logic [7:0] b, input bit dropReq, input int noiseSrc);
    exp_t e;
    int   s;
    int   n;
    s = pickNext(src_req, rrModel);
    expTotal = expTotal + 16'd1;
    e.data = b;
    e.src = SW'(s);
    e.total = expTotal;
    expQ.push_back(e);
    expectedPushes++;
    n = 0;
    while (src_grant == '0 && n < 60) begin
      @(negedge clock_100KHZ);
      n++;
    end
    if (src_grant == '0) begin
      checkOutput("grant_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("grant_onehot", {28'd0, src_grant}, 32'd1 << s);
    if (dropReq) src_req = '0;
    @(negedge clock_100KHZ);
    for (int i = 7; i >= 0; i--) begin
      src_data_in[s] = b[i];
      src_write_in[s] = 1'b1;
      if (noiseSrc >= 0) begin
        src_write_in[noiseSrc] = 1'b0;
        src_data_in[noiseSrc] = ~b[i];
      end
      #1;
      checkOutput("fwd_write", {31'd0, deser_write_in}, 32'd1);
      checkOutput("fwd_data", {31'd0, deser_data_in}, {31'd0, b[i]});
      @(negedge clock_100KHZ);
      if (noiseSrc >= 0) begin
        src_write_in[s] = 1'b0;
        src_write_in[noiseSrc] = 1'b1;
        src_data_in[noiseSrc] = ~b[i];
        #1;
        checkOutput("noise_blocked", {31'd0, deser_write_in}, 32'd0);
        @(negedge clock_100KHZ);
      end
    end
    src_write_in = '0;
    src_data_in = '0;
    rrModel = (s + 1) % NUM_SRC;
  endtask

  task automatic waitPushes();
    int n;
    n = 0;
    while (pushSeen != expectedPushes && n < 200) begin
      @(negedge clock_100KHZ);
      n++;
    end
    checkOutput("push_count", pushSeen, expectedPushes);
    repeat (3) @(negedge clock_100KHZ);
    checkOutput("grant_idle", {28'd0, src_grant}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int strobes;
    int n;
    #2 reset = 1'b0;
    #1 checkResetState();
    @(negedge clock_100KHZ);
    reset = 1'b1;
    @(negedge clock_100KHZ);

    $display("[TB] single source 0xA5");
    src_req = 4'b0001;
    applyStimulus(8'hA5, 1'b1, -1);
    waitPushes();

    $display("[TB] round-robin, all sources requesting");
    applyReset();
    src_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'(pickNext(src_req, rrModel)), k == 4, -1);
    end
    waitPushes();

    $display("[TB] back-pressure for 20 cycles");
    q_full = 1'b1;
    src_req = 4'b0100;
    applyStimulus(8'h3C, 1'b1, -1);
    n = 0;
    while (!deser_data_ready && n < 20) begin
      @(negedge clock_100KHZ);
      n++;
    end
    checkOutput("bp_data_ready", {31'd0, deser_data_ready}, 32'd1);
    strobes = 0;
    repeat (20) begin
      @(negedge clock_100KHZ);
      if (q_push || deser_ack) strobes++;
    end
    checkOutput("bp_no_strobe", strobes, 32'd0);
    q_full = 1'b0;
    waitPushes();

    $display("[TB] non-granted noise on source 2");
    src_req = 4'b0010;
    applyStimulus(8'h96, 1'b1, 2);
    waitPushes();

    $display("[TB] reset mid-byte");
    src_req = 4'b0010;
    n = 0;
    while (src_grant == '0 && n < 60) begin
      @(negedge clock_100KHZ);
      n++;
    end
    checkOutput("mid_grant", {28'd0, src_grant}, 32'd2);
    src_req = '0;
    @(negedge clock_100KHZ);
    for (int i = 7; i >= 4; i--) begin
      src_data_in[1] = i[0];
      src_write_in[1] = 1'b1;
      @(negedge clock_100KHZ);
    end
    reset = 1'b0;
    #1 checkResetState();
    applyReset();
    src_req = 4'b1000;
    applyStimulus(8'h5A, 1'b1, -1);
    waitPushes();

    $display("[TB] bytes_total wrap");
    force dut.bytes_total = 16'hFFFF;
    #1;
    release dut.bytes_total;
    #1 checkOutput("preload", {16'd0, bytes_total}, 32'h0000FFFF);
    expTotal = 16'hFFFF;
    @(negedge clock_100KHZ);
    src_req = 4'b0001;
    applyStimulus(8'h7E, 1'b1, -1);
    waitPushes();
    checkOutput("wrap_total", {16'd0, bytes_total}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
